// File: rtl/rr_arb_4_1.sv
// Four-channel round-robin arbiter with a single registered output stage.
// The pointer names the highest-priority channel and advances past each winner.
module rr_arb_4_1 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  logic [1:0]   ptr_q, ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [1:0]   out_sel_q, out_sel_d;

  logic         load;
  logic         accept;
  logic [1:0]   gnt;
  logic [W-1:0] gnt_data;

  // Grant search: first requester scanning ptr, ptr+1, ... with 2-bit wrap.
  // Looping from the farthest offset down lets the nearest requester win last.
  always_comb begin
    logic [1:0] idx;
    gnt = ptr_q;
    idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) gnt = idx;
    end
  end

  // Payload of the granted channel.
  always_comb begin
    gnt_data = in_data0;
    unique case (gnt)
      2'd0: gnt_data = in_data0;
      2'd1: gnt_data = in_data1;
      2'd2: gnt_data = in_data2;
      2'd3: gnt_data = in_data3;
      default: gnt_data = in_data0;
    endcase
  end

  // Handshake: the output register can take a beat when empty or draining.
  // Reset gates accept so in_ready is low while rst is held.
  always_comb begin
    load     = !out_valid_q || out_ready;
    accept   = !rst && load && (|in_valid);
    in_ready = accept ? (4'b0001 << gnt) : 4'b0000;
  end

  // Next state: accept loads a new beat, a drain without accept empties the stage.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt;
      ptr_d       = gnt + 2'd1;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
